load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits directly downstream of the scheduling queue front stage.
- Consumes its LSU request (start/cmd/width/tag) together with the AGU effective address and the store operand.
- Runs byte or little-endian word transfers over an 8-bit memory bus.
- Stalls the front stage through lsu_wait, and returns load data tagged for the owning reservation station (00 = station A, 01 = station B).

Parameters:
- TIMEOUT_CYCLES, 0: maximum cycles a beat waits for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- a_rst  in  1  asynchronous active-high reset
- rq_start  in  1  request valid; sampled only in IDLE
- rq_cmd  in  1  1 = store, 0 = load
- rq_width  in  1  1 = 16-bit word, 0 = byte
- rq_tag  in  1  issuing station (0 = A, 1 = B)
- agu_adr  in  16  effective address
- st_data  in  16  store operand; only [7:0] is used for byte stores
- lsu_wait  out  1  busy; the front stage must hold its request
- mem_adr  out  16  bus address
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_wdata  out  8  bus write data
- mem_rdata  in  8  bus read data, valid with mem_ack
- mem_ack  in  1  beat complete
- lsu_data  out  16  load result
- lsu_data_tag  out  2  {1'b0, captured tag}
- lsu_data_wb  out  1  one-cycle load writeback strobe
- bus_err  out  1  one-cycle strobe on timeout abort

Behaviour:
- Reset value of every output is 0; state is IDLE.
- Reset asserted mid-transfer aborts immediately: mem_req drops asynchronously, and no wb or err pulse is produced.

States:
- IDLE: if rq_start, capture address, cmd, width, tag and st_data, then go to LO. The accept cycle has lsu_wait = 0 so the front stage advances.
- LO: mem_req = 1, mem_adr = captured address, mem_we = cmd, mem_wdata = data[7:0]. On mem_ack, latch rdata into result[7:0], then:
  - word: go to HI;
  - byte load: go to WB;
  - byte store: go to IDLE.
- HI: mem_adr = captured address + 1, modulo 2^16, so 0xFFFF wraps to 0x0000. mem_wdata = data[15:8]. On mem_ack, latch result[15:8]; go to WB for a load, IDLE for a store.
- WB: lsu_data_wb = 1 for exactly one cycle; lsu_data and lsu_data_tag are valid during that cycle. Then go to IDLE.

Data and timing rules:
- Byte loads are zero-extended: result[15:8] = 0.
- lsu_data holds its value until the next writeback; lsu_data_tag is registered.
- lsu_wait = (state != IDLE), registered-state decode, no combinational path from rq_*.
- A back-to-back request is accepted in the first IDLE cycle after completion.
- Minimum latencies with mem_ack in the same cycle as mem_req:
  - byte store: 2 cycles;
  - word store: 3 cycles;
  - byte load: wb on the 3rd cycle after accept;
  - word load: wb on the 4th cycle after accept.
- mem_req stays high across a beat until mem_ack. mem_adr, mem_we and mem_wdata are stable while mem_req is high.
- mem_ack outside LO/HI is ignored.

Timeout (TIMEOUT_CYCLES > 0):
- The counter resets at each beat start.
- When it reaches TIMEOUT_CYCLES without mem_ack:
  - pulse bus_err for one cycle;
  - drop mem_req;
  - a load proceeds to WB with lsu_data = 0, so the station is never left waiting forever;
  - a store returns to IDLE.
- mem_ack arriving in the same cycle as expiry wins; the beat completes normally.

Inputs after accept:
- rq_start arriving while busy is not captured; the front stage holds it via lsu_wait.
- Changes on agu_adr or st_data after accept have no effect.

Decomposition:
- Shared package holds:
  - state encodings LSU_IDLE / LSU_LO / LSU_HI / LSU_WB (2-bit);
  - constants LSU_CMD_LD = 0, LSU_CMD_ST = 1, LSU_W_BYTE = 0, LSU_W_WORD = 1;
  - tag constants TAG_RSA = 2'b00, TAG_RSB = 2'b01.
- The package is shared with scheduling_queue.
- One sub-module, lsu_beat_timer: timeout counter with start/ack/expire; instantiated only when TIMEOUT_CYCLES > 0.

Test Plan:
- Byte load: rq_start, cmd = 0, width = 0, tag = 1, adr = 0x1234; ack with rdata = 0xAB -> one mem beat at 0x1234, we = 0; wb pulse with lsu_data = 0x00AB, tag = 01; lsu_wait high from accept+1 until wb.
- Word store: cmd = 1, width = 1, adr = 0x2000, st_data = 0xBEEF -> beats (0x2000, we = 1, 0xEF) then (0x2001, 0xBE); no wb; lsu_wait low on the cycle after the second ack.
- Word load with wrap: adr = 0xFFFF, rdata 0x34 then 0x12 -> addresses 0xFFFF then 0x0000; wb with lsu_data = 0x1234, tag = 00.
- Wait states and back-to-back: ack delayed 3 cycles per beat, second request held on rq_start -> mem_adr and mem_req stable throughout; second request accepted only on the first IDLE cycle after the first completes.
- Timeout, with TIMEOUT_CYCLES = 4 and no ack on a byte load -> bus_err pulse after 4 cycles; wb with lsu_data = 0x0000.
- Timeout, with ack arriving on the 4th cycle -> normal completion, no bus_err.
- Reset during the HI beat of a word load -> mem_req = 0 immediately; no lsu_data_wb; the next request after reset release completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit and the scheduling queue that
// feeds it: FSM state encoding, command/width encodings, station tags and
// small helpers used by both sides.
// ----------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_LO   = 2'd1,
        LSU_HI   = 2'd2,
        LSU_WB   = 2'd3
    } lsu_state_t;

    localparam logic LSU_CMD_LD = 1'b0;
    localparam logic LSU_CMD_ST = 1'b1;
    localparam logic LSU_W_BYTE = 1'b0;
    localparam logic LSU_W_WORD = 1'b1;

    localparam logic [1:0] TAG_RSA = 2'b00;
    localparam logic [1:0] TAG_RSB = 2'b01;

    // Address of the upper byte of a little-endian word; wraps at 64 KiB.
    function automatic logic [15:0] lsu_next_adr(input logic [15:0] adr);
        return adr + 16'd1;
    endfunction

    // Map the one-bit issuing-station id onto the writeback tag.
    function automatic logic [1:0] lsu_station_tag(input logic tag);
        return tag ? TAG_RSB : TAG_RSA;
    endfunction

endpackage

// File: rtl/load_store_unit_beat_timer.sv
// ----------------------------------------------------------------------------
// lsu_beat_timer
// Counts the cycles a memory beat has been outstanding and flags expiry on
// the TIMEOUT_CYCLES-th cycle of the beat without an acknowledge.
//
// Ports:
//   clk     system clock
//   a_rst   asynchronous active-high reset
//   start   pulse: a new beat begins on the next cycle (clears the count)
//   active  a beat is currently outstanding
//   ack     the beat completes this cycle
//   expire  combinational: this is the last allowed cycle of the beat
// ----------------------------------------------------------------------------
module lsu_beat_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4
) (
    input  logic clk,
    input  logic a_rst,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_reg;

    // Count 0 is the first cycle of the beat, so expiry is seen on the
    // TIMEOUT_CYCLES-th cycle; the count freezes once expired.
    assign expire = active && (cnt_reg == LAST);

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            cnt_reg <= '0;
        end else if (start) begin
            cnt_reg <= '0;
        end else if (active && !ack && !expire) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Executes byte / little-endian word loads and stores over an 8-bit memory
// bus on behalf of the scheduling queue. A request is captured in IDLE, run
// as one (byte) or two (word, low byte first) bus beats, and loads are
// written back with a one-cycle strobe tagged for the issuing station.
// An optional per-beat timeout aborts a hung beat with a bus_err pulse.
//
// Ports:
//   clk, a_rst            clock, asynchronous active-high reset
//   rq_start/cmd/width/tag request from the front stage (cmd 1 = store,
//                         width 1 = word, tag 0 = station A / 1 = B)
//   agu_adr, st_data      effective address and store operand
//   lsu_wait              busy, front stage must hold its request
//   mem_adr/req/we/wdata  bus request side
//   mem_rdata, mem_ack    bus response side
//   lsu_data, lsu_data_tag, lsu_data_wb   load writeback
//   bus_err               one-cycle strobe on a timed-out beat
// ----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        rq_start,
    input  logic        rq_cmd,
    input  logic        rq_width,
    input  logic        rq_tag,
    input  logic [15:0] agu_adr,
    input  logic [15:0] st_data,
    output logic        lsu_wait,
    output logic [15:0] mem_adr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] lsu_data,
    output logic [1:0]  lsu_data_tag,
    output logic        lsu_data_wb,
    output logic        bus_err
);

    lsu_state_t  state_reg, state_next;

    logic [15:0] adr_reg;
    logic [15:0] data_reg;
    logic        cmd_reg;
    logic        width_reg;
    logic        tag_reg;
    logic [7:0]  res_lo_reg;
    logic [15:0] lsu_data_reg;
    logic [1:0]  tag_out_reg;
    logic        bus_err_reg;

    logic        in_beat;
    logic        in_lo;
    logic        in_hi;
    logic        beat_expire;
    logic        timed_out;
    logic [15:0] wb_value;

    assign in_lo     = (state_reg == LSU_LO);
    assign in_hi     = (state_reg == LSU_HI);
    assign in_beat   = in_lo || in_hi;
    // An acknowledge in the expiry cycle takes priority over the abort.
    assign timed_out = in_beat && !mem_ack && beat_expire;

    // ---------------------------------------------------------------- timer
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            logic beat_start;

            // Entering LO or HI from a different state starts a new beat.
            assign beat_start = ((state_next == LSU_LO) || (state_next == LSU_HI))
                                && (state_next != state_reg);

            lsu_beat_timer #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_beat_timer (
                .clk    (clk),
                .a_rst  (a_rst),
                .start  (beat_start),
                .active (in_beat),
                .ack    (mem_ack),
                .expire (beat_expire)
            );
        end else begin : g_no_timer
            assign beat_expire = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------ next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LSU_IDLE: begin
                if (rq_start) begin
                    state_next = LSU_LO;
                end
            end
            LSU_LO: begin
                if (mem_ack) begin
                    if (width_reg == LSU_W_WORD) begin
                        state_next = LSU_HI;
                    end else if (cmd_reg == LSU_CMD_LD) begin
                        state_next = LSU_WB;
                    end else begin
                        state_next = LSU_IDLE;
                    end
                end else if (beat_expire) begin
                    state_next = (cmd_reg == LSU_CMD_LD) ? LSU_WB : LSU_IDLE;
                end
            end
            LSU_HI: begin
                if (mem_ack || beat_expire) begin
                    state_next = (cmd_reg == LSU_CMD_LD) ? LSU_WB : LSU_IDLE;
                end
            end
            LSU_WB: begin
                state_next = LSU_IDLE;
            end
            default: begin
                state_next = LSU_IDLE;
            end
        endcase
    end

    // Value written back when a load leaves its last beat. A timed-out beat
    // has no ack, so the result collapses to zero.
    always_comb begin
        wb_value = 16'h0000;
        if (mem_ack) begin
            wb_value = in_hi ? {mem_rdata, res_lo_reg} : {8'h00, mem_rdata};
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_reg    <= LSU_IDLE;
            adr_reg      <= '0;
            data_reg     <= '0;
            cmd_reg      <= LSU_CMD_LD;
            width_reg    <= LSU_W_BYTE;
            tag_reg      <= 1'b0;
            res_lo_reg   <= '0;
            lsu_data_reg <= '0;
            tag_out_reg  <= TAG_RSA;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bus_err_reg <= timed_out;

            if ((state_reg == LSU_IDLE) && rq_start) begin
                adr_reg   <= agu_adr;
                data_reg  <= st_data;
                cmd_reg   <= rq_cmd;
                width_reg <= rq_width;
                tag_reg   <= rq_tag;
            end

            if (in_lo && mem_ack) begin
                res_lo_reg <= mem_rdata;
            end

            // lsu_data/tag only change on the way into WB, so they hold the
            // last load result between writebacks.
            if (state_next == LSU_WB) begin
                lsu_data_reg <= wb_value;
                tag_out_reg  <= lsu_station_tag(tag_reg);
            end
        end
    end

    // --------------------------------------------------------------- outputs
    // Bus outputs decode from the state register only, so they fall to zero
    // the instant reset asserts.
    assign lsu_wait     = (state_reg != LSU_IDLE);
    assign mem_req      = in_beat;
    assign mem_we       = in_beat && (cmd_reg == LSU_CMD_ST);
    assign mem_adr      = in_lo ? adr_reg :
                          in_hi ? lsu_next_adr(adr_reg) : 16'h0000;
    assign mem_wdata    = in_lo ? data_reg[7:0] :
                          in_hi ? data_reg[15:8] : 8'h00;
    assign lsu_data     = lsu_data_reg;
    assign lsu_data_tag = tag_out_reg;
    assign lsu_data_wb  = (state_reg == LSU_WB);
    assign bus_err      = bus_err_reg;

endmodule
